piso_serial_ctrl: RTL and testbench

//  Controller that sequences a WIDTH-bit parallel-in/serial-out shift register.
//  - Accepts parallel words over a valid/ready handshake.
//  - Loads each word into its shift datapath and streams it LSB-first on a serial output.
//  - The serial output has its own valid/ready handshake.
//  - Sits between a word-producing block and any bit-serial consumer.

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso_shift_core.sv | 34 +++
 rtl/piso_serial_ctrl.sv | 118 +++++++++++
 tb/tb_piso_serial_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serial controller.
// The macro PISO_PARITY_EN (consumed by piso_serial_ctrl) appends an even-parity bit to each frame.
package piso_pkg;
    localparam int PISO_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;
endpackage

// File: rtl/piso_shift_core.sv
// Load/shift-enable register: parallel load wins over a right shift with zero fill.
// q is the current LSB, which is the serial bit on the wire.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic nb;
        if (i == WIDTH - 1) begin : g_top
            assign nb = 1'b0;
        end else begin : g_mid
            assign nb = sh_q[i+1];
        end
        assign sh_d[i] = load ? d[i] : (shift ? nb : sh_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= sh_d;
    end

    assign q = sh_q[0];
endmodule

// File: rtl/piso_serial_ctrl.sv
// Sequences a WIDTH-bit PISO register: parallel valid/ready in, LSB-first serial valid/ready out.
// Define PISO_PARITY_EN to append an even-parity bit after bit WIDTH-1 of each frame.
module piso_serial_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift, core_q;

    assign load = in_valid & in_ready;
    assign busy = (state_q != ST_IDLE);

`ifdef PISO_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    par_q <= 1'b0;
        else if (load) par_q <= ^in_data;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift     = 1'b0;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = core_q;
                ser_first = (cnt_q == '0);
`ifdef PISO_PARITY_EN
                if (ser_ready) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = ST_PARITY;
                end
`else
                ser_last = (cnt_q == LAST_CNT);
                in_ready = ser_last & ser_ready;
                if (ser_ready) begin
                    shift = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // Reload on the last bit keeps frames back-to-back.
                        cnt_d = '0;
                        if (!in_valid) state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                ser_valid = 1'b1;
                ser_out   = par_q;
                ser_last  = 1'b1;
                in_ready  = ser_ready;
                if (ser_ready) begin
                    cnt_d   = '0;
                    state_d = in_valid ? ST_SHIFT : ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .d     (in_data),
        .q     (core_q)
    );
endmodule

// File: tb/tb_piso_serial_ctrl.sv
// Directed self-checking bench for piso_serial_ctrl (WIDTH=4), parity-aware via PISO_PARITY_EN.
module tb_piso_serial_ctrl;
`ifdef PISO_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [3:0] in_data;
    logic       ser_out, ser_valid, ser_ready, ser_first, ser_last, busy;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    piso_serial_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, 8'(in_ready), 8'd1);
        chk({tag, ".ser_valid"}, 8'(ser_valid), 8'd0);
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".ser_out"}, 8'(ser_out), 8'd0);
    endtask

    // Present a word in IDLE; it is accepted on the following edge.
    task automatic offer(input string tag, input logic [3:0] w);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        chk({tag, ".offer_ready"}, 8'(in_ready), 8'd1);
        cyc();
    endtask

    // Check one frame with ser_ready high; exp holds the bits LSB-first (bit 4 = parity).
    task automatic run_frame(input string tag, input logic [4:0] exp, input logic nv, input logic [3:0] nd);
        for (int i = 0; i < NB; i++) begin
            in_valid  = nv;
            in_data   = nd;
            ser_ready = 1'b1;
            #1;
            chk($sformatf("%s.b%0d.valid", tag, i), 8'(ser_valid), 8'd1);
            chk($sformatf("%s.b%0d.out", tag, i), 8'(ser_out), 8'(exp[i]));
            chk($sformatf("%s.b%0d.first", tag, i), 8'(ser_first), 8'(i == 0));
            chk($sformatf("%s.b%0d.last", tag, i), 8'(ser_last), 8'(i == NB - 1));
            chk($sformatf("%s.b%0d.in_ready", tag, i), 8'(in_ready), 8'(i == NB - 1));
            chk($sformatf("%s.b%0d.busy", tag, i), 8'(busy), 8'd1);
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; ser_ready = 1'b0;
        #3;
        chk_idle("reset0");
        chk("reset0.first", 8'(ser_first), 8'd0);
        chk("reset0.last", 8'(ser_last), 8'd0);
        cyc();
        rst_n = 1'b1;
        ser_ready = 1'b1;

        // Single word 1011 -> 1,1,0,1 (parity 1)
        offer("single", 4'b1011);
        run_frame("single", 5'b1_1011, 1'b0, 4'h0);
        #1;
        chk_idle("single.after");
        cyc();

        // Back-to-back A then 5 -> 0,1,0,1,1,0,1,0 with no gap
        offer("b2b", 4'hA);
        run_frame("b2b.A", 5'b0_1010, 1'b1, 4'h5);
        run_frame("b2b.5", 5'b0_0101, 1'b0, 4'h0);
        #1;
        chk_idle("b2b.after");
        cyc();

        // Stall at bit 2 of C (bits 0,0,1,1; parity 0); offered word during stall is ignored
        offer("stall", 4'hC);
        in_valid = 1'b0;
        #1;
        chk("stall.b0.out", 8'(ser_out), 8'd0);
        chk("stall.b0.first", 8'(ser_first), 8'd1);
        cyc();
        #1;
        chk("stall.b1.out", 8'(ser_out), 8'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            ser_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 4'h3;
            #1;
            chk($sformatf("stall.hold%0d.out", k), 8'(ser_out), 8'd1);
            chk($sformatf("stall.hold%0d.valid", k), 8'(ser_valid), 8'd1);
            chk($sformatf("stall.hold%0d.in_ready", k), 8'(in_ready), 8'd0);
            chk($sformatf("stall.hold%0d.first", k), 8'(ser_first), 8'd0);
            chk($sformatf("stall.hold%0d.last", k), 8'(ser_last), 8'd0);
            cyc();
        end
        ser_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        chk("stall.b2.out", 8'(ser_out), 8'd1);
        chk("stall.b2.in_ready", 8'(in_ready), 8'd0);
        cyc();
        #1;
        chk("stall.b3.out", 8'(ser_out), 8'd1);
`ifdef PISO_PARITY_EN
        chk("stall.b3.last", 8'(ser_last), 8'd0);
        cyc();
        #1;
        chk("stall.par.out", 8'(ser_out), 8'd0);
`endif
        chk("stall.end.last", 8'(ser_last), 8'd1);
        chk("stall.end.in_ready", 8'(in_ready), 8'd1);
        cyc();
        #1;
        chk_idle("stall.after");
        cyc();

`ifdef PISO_PARITY_EN
        offer("par7", 4'b0111);
        run_frame("par7", 5'b1_0111, 1'b0, 4'h0);
        #1;
        chk_idle("par7.after");
        cyc();
        offer("par0", 4'b0000);
        run_frame("par0", 5'b0_0000, 1'b0, 4'h0);
        #1;
        chk_idle("par0.after");
        cyc();
`endif

        // Mid-frame reset after bit 1 of F
        offer("rst", 4'hF);
        in_valid = 1'b0;
        #1;
        chk("rst.b0.out", 8'(ser_out), 8'd1);
        cyc();
        #1;
        chk("rst.b1.out", 8'(ser_out), 8'd1);
        chk("rst.b1.valid", 8'(ser_valid), 8'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("rst.async");
        cyc();
        rst_n = 1'b1;
        #1;
        chk_idle("rst.rel");
        cyc();
        #1;
        chk_idle("rst.rel2");
        offer("rst.next", 4'h6);
        run_frame("rst.next", 5'b0_0110, 1'b0, 4'h0);
        #1;
        chk_idle("rst.next.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
